// File: rtl/mem_access_pkg.sv
// Shared definitions for the bittyCore memory-access stage.
// Holds bus widths, the load/store opcode encodings, the memory FSM state
// encoding, byte-lane select constants and small opcode-decode helpers.
package mem_access_pkg;

    // Reset level: the core resets while rst is low.
    localparam logic RstEnable = 1'b0;

    localparam int REG_ADDR_W  = 5;
    localparam int REG_W       = 32;
    localparam int ALU_OP_W    = 8;
    localparam int DATA_ADDR_W = 32;

    localparam logic [REG_ADDR_W-1:0] NOPRegAddr = 5'b00000;

    // ALU operation codes seen by this stage
    localparam logic [ALU_OP_W-1:0] EXE_NOP = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_ADD = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LB  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LH  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LW  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_LBU = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LHU = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_SB  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW  = 8'b1110_1011;

    // Memory FSM encoding
    typedef enum logic [1:0] {
        MemIdle = 2'd0,
        MemBus  = 2'd1,
        MemDone = 2'd2
    } mem_state_t;

    // Byte-lane enables
    localparam logic [3:0] SelByte0  = 4'b0001;
    localparam logic [3:0] SelHalfLo = 4'b0011;
    localparam logic [3:0] SelHalfHi = 4'b1100;
    localparam logic [3:0] SelWord   = 4'b1111;

    function automatic logic is_load_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_LB) || (op == EXE_LH) || (op == EXE_LW) ||
               (op == EXE_LBU) || (op == EXE_LHU);
    endfunction

    function automatic logic is_store_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
    endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
// Ports:
//   op        in   ALU operation code
//   addr_lo   in   effective address [1:0]
//   reg2      in   store data from the register file
//   rdata_q   in   captured bus read data
//   bus_sel   out  byte-lane enables for the access
//   bus_wdata out  store data replicated onto every candidate lane
//   load_data out  selected lane of rdata_q, sign- or zero-extended
//   misalign  out  access is not naturally aligned
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata_q,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
        return sgn ? {{24{b[7]}}, b} : {24'b0, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
        return sgn ? {{16{h[15]}}, h} : {16'b0, h};
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_q[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        bus_sel   = 4'b0000;
        bus_wdata = reg2;
        load_data = rdata_q;
        misalign  = 1'b0;
        case (op)
            EXE_LB, EXE_LBU, EXE_SB: begin
                bus_sel   = SelByte0 << addr_lo;
                bus_wdata = {4{reg2[7:0]}};
                load_data = extend8(byte_lane, op == EXE_LB);
            end
            EXE_LH, EXE_LHU, EXE_SH: begin
                misalign  = addr_lo[0];
                bus_sel   = addr_lo[1] ? SelHalfHi : SelHalfLo;
                bus_wdata = {2{reg2[15:0]}};
                load_data = extend16(half_lane, op == EXE_LH);
            end
            EXE_LW, EXE_SW: begin
                misalign  = |addr_lo;
                bus_sel   = SelWord;
                bus_wdata = reg2;
                load_data = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage between ex_mem and mem_wb.
// Non-memory ops pass straight through combinationally. Loads and stores run
// one req/ack bus transaction through an IDLE -> BUS -> DONE FSM while
// stall_req holds the upstream pipeline; a BUS_TIMEOUT watchdog abandons
// accesses that never see bus_ack.
// Ports:
//   clk, rst                          clock, async active-low reset
//   wd_i, wreg_i, wdata_i, aluop_i    EX/MEM result bundle
//   mem_addr_i, reg2_i                effective address, store data
//   wd_o, wreg_o, wdata_o             write-back bundle to mem_wb
//   stall_req                         hold IF..EX/MEM, bubble mem_wb
//   bus_req/we/addr/sel/wdata         registered data-bus request
//   bus_rdata, bus_ack                bus response
//   misalign_o, bus_err_o             one-cycle exception pulses
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        misalign_o,
    output logic        bus_err_o
);

    // Counter value in the final permitted BUS cycle: BUS lasts at most
    // BUS_TIMEOUT cycles counting from 0.
    localparam logic [7:0] TimeoutLast = 8'(BUS_TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        load_op, store_op, mem_op;
    logic        misalign;
    logic        timeout_hit;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [31:0] load_data;

    assign load_op     = is_load_op(aluop_i);
    assign store_op    = is_store_op(aluop_i);
    assign mem_op      = load_op | store_op;
    assign timeout_hit = (cnt_q == TimeoutLast);

    mem_lane_align u_lane (
        .op        (aluop_i),
        .addr_lo   (mem_addr_i[1:0]),
        .reg2      (reg2_i),
        .rdata_q   (rdata_q),
        .bus_sel   (sel_c),
        .bus_wdata (wdata_c),
        .load_data (load_data),
        .misalign  (misalign)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MemIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus_ack only matters while in BUS
    always_comb begin
        state_d = state_q;
        case (state_q)
            MemIdle: if (mem_op && !misalign) state_d = MemBus;
            MemBus:  if (bus_ack || timeout_hit) state_d = MemDone;
            MemDone: state_d = MemIdle;
            default: state_d = MemIdle;
        endcase
    end

    // Bus request, timeout counter, error flag and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_sel   <= 4'b0000;
            bus_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            cnt_q     <= 8'h0;
            err_q     <= 1'b0;
        end else if (state_q == MemIdle && state_d == MemBus) begin
            bus_req   <= 1'b1;
            bus_we    <= store_op;
            bus_addr  <= {mem_addr_i[31:2], 2'b00};
            bus_sel   <= sel_c;
            bus_wdata <= wdata_c;
            cnt_q     <= 8'h0;
            err_q     <= 1'b0;
        end else if (state_q == MemBus) begin
            if (bus_ack) begin
                rdata_q <= bus_rdata;
                bus_req <= 1'b0;
            end else if (timeout_hit) begin
                bus_req <= 1'b0;
                err_q   <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + 8'd1;
            end
        end
    end

    // Output logic. Reset forces the write-back bundle to a bubble right
    // away, without waiting for a clock edge.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stall_req  = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        if (rst == RstEnable) begin
            wd_o    = NOPRegAddr;
            wreg_o  = 1'b0;
            wdata_o = 32'h0;
        end else begin
            case (state_q)
                MemIdle: begin
                    if (mem_op) begin
                        wreg_o = 1'b0;
                        if (misalign) misalign_o = 1'b1;
                        else          stall_req  = 1'b1;
                    end
                end
                MemBus: begin
                    stall_req = 1'b1;
                    wreg_o    = 1'b0;
                end
                MemDone: begin
                    if (err_q) begin
                        wreg_o    = 1'b0;
                        bus_err_o = 1'b1;
                    end else if (store_op) begin
                        wreg_o = 1'b0;
                    end else if (load_op) begin
                        wdata_o = load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        misalign_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;
    int sc;
    int n;
    int errs;

    always #5 clk = ~clk;

    mem_access #(.BUS_TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stall_req  (stall_req),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_sel    (bus_sel),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic [4:0] wd, input logic wr);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        wd_i       = wd;
        wreg_i     = wr;
        wdata_i    = addr;
    endtask

    initial begin
        rst        = 1'b0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;
        aluop_i    = EXE_ADD;
        wd_i       = 5'd5;
        wreg_i     = 1'b1;
        wdata_i    = 32'h1234;
        mem_addr_i = 32'h0;
        reg2_i     = 32'h0;
        step();
        step();
        #1;
        chk("rst_wd_o", 32'(wd_o), 32'd0);
        chk("rst_wreg_o", 32'(wreg_o), 32'd0);
        chk("rst_wdata_o", wdata_o, 32'h0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);

        // Passthrough of an ADD result
        rst = 1'b1;
        #1;
        chk("pt_wdata", wdata_o, 32'h1234);
        chk("pt_wd", 32'(wd_o), 32'd5);
        chk("pt_wreg", 32'(wreg_o), 32'd1);
        chk("pt_stall", 32'(stall_req), 32'd0);
        step();
        chk("pt_stall_next", 32'(stall_req), 32'd0);

        // LB at 0x103, ack in first BUS cycle
        set_op(EXE_LB, 32'h103, 32'h0, 5'd7, 1'b1);
        bus_rdata = 32'h80FF_0011;
        #1;
        sc = 0;
        chk("lb_idle_stall", 32'(stall_req), 32'd1);
        chk("lb_idle_wreg", 32'(wreg_o), 32'd0);
        sc += 32'(stall_req);
        step();
        chk("lb_req", 32'(bus_req), 32'd1);
        chk("lb_addr", bus_addr, 32'h100);
        chk("lb_sel", 32'(bus_sel), 32'h8);
        chk("lb_we", 32'(bus_we), 32'd0);
        sc += 32'(stall_req);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        #1;
        chk("lb_done_stall", 32'(stall_req), 32'd0);
        chk("lb_done_wreg", 32'(wreg_o), 32'd1);
        chk("lb_done_wd", 32'(wd_o), 32'd7);
        chk("lb_done_wdata", wdata_o, 32'hFFFF_FF80);
        chk("lb_done_req", 32'(bus_req), 32'd0);
        chk("lb_stall_cycles", 32'(sc), 32'd2);
        step();

        // SH of 0xABCD1234 at 0x202, ack after 3 wait cycles
        set_op(EXE_SH, 32'h202, 32'hABCD_1234, 5'd3, 1'b1);
        #1;
        sc = 32'(stall_req);
        step();
        chk("sh_sel", 32'(bus_sel), 32'hC);
        chk("sh_wdata", bus_wdata, 32'h1234_1234);
        chk("sh_we", 32'(bus_we), 32'd1);
        chk("sh_addr", bus_addr, 32'h200);
        for (int i = 0; i < 4; i++) begin
            sc += 32'(stall_req);
            bus_ack = (i == 3);
            step();
        end
        bus_ack = 1'b0;
        #1;
        chk("sh_done_stall", 32'(stall_req), 32'd0);
        chk("sh_done_wreg", 32'(wreg_o), 32'd0);
        chk("sh_stall_cycles", 32'(sc), 32'd5);
        step();

        // Misaligned LW at 0x101
        set_op(EXE_LW, 32'h101, 32'h0, 5'd9, 1'b1);
        #1;
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_stall", 32'(stall_req), 32'd0);
        chk("mis_wreg", 32'(wreg_o), 32'd0);
        chk("mis_req", 32'(bus_req), 32'd0);
        step();
        chk("mis_req_next", 32'(bus_req), 32'd0);
        set_op(EXE_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);

        // SB at 0x301: lane 1, byte replicated
        set_op(EXE_SB, 32'h301, 32'h1122_335A, 5'd4, 1'b1);
        #1;
        step();
        chk("sb_sel", 32'(bus_sel), 32'h2);
        chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        #1;
        chk("sb_done_wreg", 32'(wreg_o), 32'd0);
        step();

        // LHU with no ack: timeout
        set_op(EXE_LHU, 32'h10, 32'h0, 5'd6, 1'b1);
        #1;
        step();
        n = 0;
        errs = 0;
        while (bus_req === 1'b1 && n < 300) begin
            n++;
            errs += 32'(bus_err_o);
            step();
        end
        chk("to_bus_cycles", 32'(n), 32'd255);
        chk("to_err_early", 32'(errs), 32'd0);
        #1;
        chk("to_err_pulse", 32'(bus_err_o), 32'd1);
        chk("to_wreg", 32'(wreg_o), 32'd0);
        chk("to_stall", 32'(stall_req), 32'd0);
        step();
        chk("to_err_end", 32'(bus_err_o), 32'd0);

        // Following LHU at 0x22 completes normally: upper half, zero-extended
        set_op(EXE_LHU, 32'h22, 32'h0, 5'd6, 1'b1);
        bus_rdata = 32'h8001_0000;
        #1;
        step();
        chk("lhu_addr", bus_addr, 32'h20);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        #1;
        chk("lhu_wreg", 32'(wreg_o), 32'd1);
        chk("lhu_wdata", wdata_o, 32'h0000_8001);
        chk("lhu_err", 32'(bus_err_o), 32'd0);
        step();

        // Reset in the middle of a BUS wait, then a late ack
        set_op(EXE_LW, 32'h40, 32'h0, 5'd8, 1'b1);
        bus_rdata = 32'h55AA_55AA;
        #1;
        step();
        step();
        chk("mid_req_before", 32'(bus_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_addr", bus_addr, 32'h0);
        chk("mid_rst_sel", 32'(bus_sel), 32'h0);
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        chk("mid_rst_wd", 32'(wd_o), 32'd0);
        chk("mid_rst_wreg", 32'(wreg_o), 32'd0);
        chk("mid_rst_wdata", wdata_o, 32'h0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_stall", 32'(stall_req), 32'd1);
        chk("post_rst_req", 32'(bus_req), 32'd0);
        chk("post_rst_wreg", 32'(wreg_o), 32'd0);
        step();
        chk("post_rst_req_bus", 32'(bus_req), 32'd1);
        bus_rdata = 32'h0BAD_F00D;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        #1;
        chk("post_rst_wdata", wdata_o, 32'h0BAD_F00D);
        chk("post_rst_done_wreg", 32'(wreg_o), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
